// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   muldiv_op_t        : operation selector driven on muldiv_unit.op
//   state_t            : control FSM states of muldiv_unit
//   DIV0_QUOT_ALL_ONES : fill bit for the quotient produced by a divide by zero
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } muldiv_op_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   // A divide by zero returns a quotient with every bit set to this value.
   localparam logic DIV0_QUOT_ALL_ONES = 1'b1;

endpackage : muldiv_pkg

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational result fixup shared by multiply and divide.
// The iteration datapath works on magnitudes; this block restores signs and
// handles the divide-by-zero result.
// Ports:
//   is_div_i     : 1 = accumulator holds {remainder, quotient}, 0 = product
//   div0_i       : divisor was zero
//   neg_lo_i     : negate product (multiply) or quotient (divide)
//   neg_hi_i     : negate remainder (divide only)
//   acc_i        : 2*WIDTH-bit final accumulator from the iteration datapath
//   dividend_i   : original (unsigned-interpreted) dividend, returned in HI on div0
//   hi_o / lo_o  : values to be written into HI / LO
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 is_div_i,
   input  logic                 div0_i,
   input  logic                 neg_lo_i,
   input  logic                 neg_hi_i,
   input  logic [2*WIDTH-1:0]   acc_i,
   input  logic [WIDTH-1:0]     dividend_i,
   output logic [WIDTH-1:0]     hi_o,
   output logic [WIDTH-1:0]     lo_o
);

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   always_comb begin
      prod = neg_lo_i ? -acc_i : acc_i;
      quo  = acc_i[WIDTH-1:0];
      rem  = acc_i[2*WIDTH-1:WIDTH];
      hi_o = prod[2*WIDTH-1:WIDTH];
      lo_o = prod[WIDTH-1:0];
      if (div0_i) begin
         hi_o = dividend_i;
         lo_o = {WIDTH{DIV0_QUOT_ALL_ONES}};
      end else if (is_div_i) begin
         // Truncating division: quotient sign from the operand signs,
         // remainder sign from the dividend.
         lo_o = neg_lo_i ? -quo : quo;
         hi_o = neg_hi_i ? -rem : rem;
      end
   end

endmodule : muldiv_sign_fix

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the HI/LO registers.
// One bit per cycle: LSB-first shift-add multiply, restoring division.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, op       : launch MULT/MULTU/DIV/DIVU (ignored unless idle)
//   rs_val, rt_val  : multiplicand/dividend, multiplier/divisor
//   mthi, mtlo      : write wdata into HI / LO (aborts any operation)
//   wdata           : MTHI/MTLO data
//   flush           : abort in-flight operation without touching HI/LO
//   busy            : high while an operation is in flight (stall request)
//   done            : one-cycle pulse when HI/LO take a new result
//   hi, lo          : architectural HI/LO registers
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   rs_val,
   input  logic [WIDTH-1:0]   rt_val,
   input  logic               mthi,
   input  logic               mtlo,
   input  logic [WIDTH-1:0]   wdata,
   input  logic               flush,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   localparam int CW = $clog2(WIDTH);
   // BUSY hands over to FINISH one count early: the last iteration is
   // evaluated combinationally in FINISH and written straight into HI/LO.
   localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [WIDTH-1:0]     dividend_q, dividend_d;
   logic                 is_div_q, is_div_d;
   logic                 div0_q, div0_d;
   logic                 neg_lo_q, neg_lo_d;
   logic                 neg_hi_q, neg_hi_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;

   // Operand decode for launch
   muldiv_op_t           op_e;
   logic                 op_signed;
   logic                 op_div;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;

   assign op_e      = muldiv_op_t'(op);
   assign op_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
   assign op_div    = (op_e == OP_DIV)  || (op_e == OP_DIVU);
   assign a_mag     = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
   assign b_mag     = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

   // One iteration step. The accumulator low half starts as the magnitude of
   // rs: for multiply its bits are consumed LSB-first as the product shifts
   // in from the top; for divide it is the dividend that shifts out MSB-first
   // while quotient bits shift in at the bottom.
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_trial;
   logic                 div_take;
   logic [2*WIDTH-1:0]   acc_step;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, b_q};
      div_take  = (div_shift >= {1'b0, b_q});
      if (is_div_q) begin
         // Remainder is always below the divisor, so it fits in WIDTH bits.
         acc_step = {(div_take ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_take};
      end else begin
         acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   logic [WIDTH-1:0]     fix_hi;
   logic [WIDTH-1:0]     fix_lo;

   muldiv_sign_fix #(
      .WIDTH (WIDTH)
   ) u_sign_fix (
      .is_div_i   (is_div_q),
      .div0_i     (div0_q),
      .neg_lo_i   (neg_lo_q),
      .neg_hi_i   (neg_hi_q),
      .acc_i      (acc_step),
      .dividend_i (dividend_q),
      .hi_o       (fix_hi),
      .lo_o       (fix_lo)
   );

   // Next-state logic. Priority: mthi/mtlo (abort + write) > flush > FSM.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      b_d        = b_q;
      dividend_d = dividend_q;
      is_div_d   = is_div_q;
      div0_d     = div0_q;
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;

      if (mthi || mtlo) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         if (mthi) hi_d = wdata;
         if (mtlo) lo_d = wdata;
      end else if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d    = S_BUSY;
                  cnt_d      = '0;
                  acc_d      = {{WIDTH{1'b0}}, a_mag};
                  b_d        = b_mag;
                  dividend_d = rs_val;
                  is_div_d   = op_div;
                  div0_d     = op_div && (rt_val == '0);
                  neg_lo_d   = op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                  neg_hi_d   = op_signed && op_div && rs_val[WIDTH-1];
               end
            end
            S_BUSY: begin
               acc_d = acc_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_PENULT) state_d = S_FINISH;
            end
            S_FINISH: begin
               hi_d    = fix_hi;
               lo_d    = fix_lo;
               done_d  = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         b_q        <= '0;
         dividend_q <= '0;
         is_div_q   <= 1'b0;
         div0_q     <= 1'b0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         b_q        <= b_d;
         dividend_q <= dividend_d;
         is_div_q   <= is_div_d;
         div0_q     <= div0_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  rs_val;
   logic [W-1:0]  rt_val;
   logic          mthi;
   logic          mtlo;
   logic [W-1:0]  wdata;
   logic          flush;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   logic [2*W-1:0] exp_q[$];

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .mthi   (mthi),
      .mtlo   (mtlo),
      .wdata  (wdata),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Scoreboard monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (!reset && done) begin
         done_cnt++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected_done: got hi=%h lo=%h, expected no done", hi, lo);
         end else begin
            logic [2*W-1:0] e;
            e = exp_q.pop_front();
            if ({hi, lo} !== e) begin
               n_bad++;
               $display("FAIL sb_result: got hi=%h lo=%h, expected hi=%h lo=%h",
                        hi, lo, e[2*W-1:W], e[W-1:0]);
            end else begin
               $display("ok   sb_result: hi=%h lo=%h", hi, lo);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives start for one cycle (cycle 0); returns at the start of cycle 1.
   task automatic issue(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
      op = o; rs_val = a; rt_val = b; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Full operation: expects busy in cycles 1..W, done at cycle W+1 with busy low.
   task automatic run_op(input string name, input muldiv_op_t o,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int k;
      int busy_err;
      int d0;
      busy_err = 0;
      d0 = done_cnt;
      exp_q.push_back({ehi, elo});
      issue(o, a, b);
      k = 1;
      while (k <= W + 8 && !done) begin
         if (!busy) busy_err++;
         tick();
         k++;
      end
      chk({name, "_latency"}, 64'(k), 64'(W + 1));
      chk({name, "_busy_window"}, 64'(busy_err), 64'd0);
      chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
      tick();
      chk({name, "_done_pulse"}, 64'(done_cnt - d0), 64'd1);
   endtask

   initial begin
      int d0;
      reset = 1'b1; start = 1'b0; op = 2'd0; rs_val = '0; rt_val = '0;
      mthi = 1'b0; mtlo = 1'b0; wdata = '0; flush = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_hi",   64'(hi),   64'd0);
      chk("reset_lo",   64'(lo),   64'd0);

      // Main function, directed vectors
      run_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_m3x7",  OP_MULT,  -32'sd3,       32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("div_m7d2",   OP_DIV,   -32'sd7,       32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_div0",  OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
      run_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_op("divu_100d7", OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);
      run_op("div_7dm2",   OP_DIV,   32'd7,         -32'sd2,       32'h0000_0001, 32'hFFFF_FFFD);
      run_op("mult_m5xm6", OP_MULT,  -32'sd5,       -32'sd6,       32'h0000_0000, 32'h0000_001E);
      run_op("multu_msb",  OP_MULTU, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000);
      run_op("div_sdiv0",  OP_DIV,   -32'sd9,       32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF);

      // mthi+mtlo together, then preload 0x11/0x22 separately
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A;
      tick();
      mthi = 1'b0; mtlo = 1'b0;
      chk("mthilo_both_hi", 64'(hi), 64'h5A);
      chk("mthilo_both_lo", 64'(lo), 64'h5A);
      mthi = 1'b1; wdata = 32'h11; tick(); mthi = 1'b0;
      mtlo = 1'b1; wdata = 32'h22; tick(); mtlo = 1'b0;
      chk("preload_hi", 64'(hi), 64'h11);
      chk("preload_lo", 64'(lo), 64'h22);

      // Flush at cycle 10 of MULTU 5*6
      d0 = done_cnt;
      issue(OP_MULTU, 32'd5, 32'd6);
      repeat (9) tick();
      flush = 1'b1; tick(); flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      repeat (30) tick();
      chk("flush_no_done", 64'(done_cnt - d0), 64'd0);
      chk("flush_hi", 64'(hi), 64'h11);
      chk("flush_lo", 64'(lo), 64'h22);

      // Flush during the FINISH cycle (cycle 32) suppresses the write
      d0 = done_cnt;
      issue(OP_MULTU, 32'd3, 32'd3);
      repeat (31) tick();
      chk("fin_flush_busy_before", 64'(busy), 64'd1);
      flush = 1'b1; tick(); flush = 1'b0;
      repeat (5) tick();
      chk("fin_flush_no_done", 64'(done_cnt - d0), 64'd0);
      chk("fin_flush_lo", 64'(lo), 64'h22);

      // flush beats start in the same cycle
      flush = 1'b1; issue(OP_MULTU, 32'd1, 32'd1); flush = 1'b0;
      chk("flush_beats_start", 64'(busy), 64'd0);

      // Second start at cycle 5 ignored
      d0 = done_cnt;
      exp_q.push_back({32'h0, 32'h6});
      issue(OP_MULTU, 32'd2, 32'd3);
      repeat (4) tick();
      op = OP_DIVU; rs_val = 32'd9; rt_val = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (27) tick();
      chk("start_busy_ignored_done", 64'(done), 64'd1);
      repeat (40) tick();
      chk("start_busy_single_done", 64'(done_cnt - d0), 64'd1);
      chk("start_busy_lo", 64'(lo), 64'h6);

      // mtlo while busy aborts the operation then writes LO
      d0 = done_cnt;
      issue(OP_MULT, 32'd9, 32'd9);
      repeat (4) tick();
      mtlo = 1'b1; wdata = 32'h77; tick(); mtlo = 1'b0;
      chk("mtlo_abort_busy", 64'(busy), 64'd0);
      chk("mtlo_abort_lo", 64'(lo), 64'h77);
      chk("mtlo_abort_hi", 64'(hi), 64'h0);
      repeat (35) tick();
      chk("mtlo_abort_no_done", 64'(done_cnt - d0), 64'd0);

      // Reset at cycle 15 of a DIVU
      d0 = done_cnt;
      issue(OP_DIVU, 32'd1000, 32'd7);
      repeat (14) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_hi", 64'(hi), 64'd0);
      chk("rst_mid_lo", 64'(lo), 64'd0);
      chk("rst_mid_done", 64'(done), 64'd0);
      repeat (30) tick();
      chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
      run_op("multu_4x4", OP_MULTU, 32'd4, 32'd4, 32'h0, 32'h10);

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_muldiv_unit
